pool_frame_scheduler: RTL and testbench

Frame-level scheduler that shares one ReLU/max-pool unit (3 channels, 2×2 window, stride 2) between two conv engines. It grants the pool to one requester for a whole INPUT_WIDTH×INPUT_WIDTH frame, round-robin. It forwards that requester's pixels into the pool and counts pixels in and pooled results out. Pooled results go back to the granted requester, and a per-requester frame-done pulse is raised. It sits between the conv stage outputs and the pool unit's `valid_in`/`conv_out_*` inputs.

---
 rtl/pool_frame_scheduler_pkg.sv | 26 ++
 rtl/pool_frame_scheduler_rr_arbiter_2.sv | 34 +++
 rtl/pool_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_pool_frame_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_frame_scheduler_pkg.sv
// Shared definitions for the pool frame scheduler: state encoding, default
// geometry and the counter-width helper used to size the pixel/result counters.
package pool_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } sched_state_e;

  localparam int unsigned CONV_BIT_DEF     = 12;
  localparam int unsigned INPUT_WIDTH_DEF  = 24;
  localparam int unsigned OUTPUT_WIDTH_DEF = INPUT_WIDTH_DEF / 2;

  localparam int unsigned IN_PIX_DEF  = INPUT_WIDTH_DEF * INPUT_WIDTH_DEF;
  localparam int unsigned OUT_PIX_DEF = OUTPUT_WIDTH_DEF * OUTPUT_WIDTH_DEF;

  // A counter must be able to hold the full count, not just count-1
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

  localparam int unsigned IN_CNT_W_DEF  = $clog2(IN_PIX_DEF + 1);
  localparam int unsigned OUT_CNT_W_DEF = $clog2(OUT_PIX_DEF + 1);

endpackage

// File: rtl/pool_frame_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer only moves when the FSM actually
// hands out a grant, so a requester that loses keeps its priority until served.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic req_0_i,
  input  logic req_1_i,
  input  logic gnt_en_i,
  output logic winner_o,
  output logic any_req_o
);

  logic rr_q;

  // Pointer decides ties; a lone requester always wins
  always_comb begin
    any_req_o = req_0_i | req_1_i;
    if (req_0_i && req_1_i) begin
      winner_o = rr_q;
    end else begin
      winner_o = req_1_i;
    end
  end

  // After each grant the pointer favours the requester that did not just win
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (gnt_en_i) begin
      rr_q <= ~winner_o;
    end
  end

endmodule

// File: rtl/pool_frame_scheduler.sv
// Frame-level scheduler sharing one ReLU/max-pool unit between two conv
// engines: grants a whole frame at a time, forwards the granted pixels into
// the pool, routes results back and flags discarded pixels/results.
module pool_frame_scheduler
  import pool_frame_scheduler_pkg::*;
#(
  parameter int unsigned CONV_BIT     = CONV_BIT_DEF,
  parameter int unsigned INPUT_WIDTH  = INPUT_WIDTH_DEF,
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  req_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  input  logic                  valid_0,
  input  logic                  valid_1,
  input  logic [3*CONV_BIT-1:0] data_0,
  input  logic [3*CONV_BIT-1:0] data_1,
  output logic                  pool_valid_in,
  output logic [CONV_BIT-1:0]   pool_conv_out_1,
  output logic [CONV_BIT-1:0]   pool_conv_out_2,
  output logic [CONV_BIT-1:0]   pool_conv_out_3,
  input  logic                  pool_valid_out,
  input  logic [CONV_BIT-1:0]   pool_max_1,
  input  logic [CONV_BIT-1:0]   pool_max_2,
  input  logic [CONV_BIT-1:0]   pool_max_3,
  output logic                  out_valid_0,
  output logic                  out_valid_1,
  output logic [3*CONV_BIT-1:0] out_data,
  output logic                  frame_done_0,
  output logic                  frame_done_1,
  output logic                  drop_err
);

  localparam int unsigned InPix   = INPUT_WIDTH * INPUT_WIDTH;
  localparam int unsigned OutPix  = OUTPUT_WIDTH * OUTPUT_WIDTH;
  localparam int unsigned InCntW  = cnt_width(InPix);
  localparam int unsigned OutCntW = cnt_width(OutPix);
  localparam logic [InCntW-1:0]  InLast  = InCntW'(InPix - 1);
  localparam logic [OutCntW-1:0] OutLast = OutCntW'(OutPix - 1);

  sched_state_e         state_q, state_d;
  logic [InCntW-1:0]    in_cnt_q, in_cnt_d;
  logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
  logic                 gnt_0_q, gnt_0_d, gnt_1_q, gnt_1_d;
  logic                 pool_valid_q;
  logic [3*CONV_BIT-1:0] pool_data_q;
  logic                 out_valid_0_q, out_valid_1_q;
  logic [3*CONV_BIT-1:0] out_data_q;
  logic                 frame_done_0_q, frame_done_1_q;
  logic                 drop_q;

  logic                 gnt_en, arb_winner, any_req;
  logic                 valid_g;
  logic [3*CONV_BIT-1:0] data_g;
  logic                 pix_accept, res_accept, frame_end, drop;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_0_i   (req_0),
    .req_1_i   (req_1),
    .gnt_en_i  (gnt_en),
    .winner_o  (arb_winner),
    .any_req_o (any_req)
  );

  // Granted-requester input mux; only meaningful while a grant is held
  always_comb begin
    valid_g = gnt_1_q ? valid_1 : valid_0;
    data_g  = gnt_1_q ? data_1  : data_0;
  end

  // Frame FSM: arbitration, pixel/result counting and discard detection
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    gnt_0_d    = gnt_0_q;
    gnt_1_d    = gnt_1_q;
    gnt_en     = 1'b0;
    pix_accept = 1'b0;
    res_accept = 1'b0;
    frame_end  = 1'b0;
    drop       = (valid_0 & ~gnt_0_q) | (valid_1 & ~gnt_1_q);
    case (state_q)
      ST_IDLE: begin
        if (pool_valid_out) begin
          drop = 1'b1;
        end
        if (any_req) begin
          gnt_en  = 1'b1;
          gnt_0_d = ~arb_winner;
          gnt_1_d = arb_winner;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_g) begin
          pix_accept = 1'b1;
          in_cnt_d   = in_cnt_q + 1'b1;
          if (in_cnt_q == InLast) begin
            state_d = ST_DRAIN;
          end
        end
        if (pool_valid_out) begin
          res_accept = 1'b1;
          out_cnt_d  = out_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The frame is complete, so any further granted pixel has nowhere to go
        if (valid_g) begin
          drop = 1'b1;
        end
        if (pool_valid_out) begin
          res_accept = 1'b1;
          if (out_cnt_q == OutLast) begin
            frame_end = 1'b1;
            gnt_0_d   = 1'b0;
            gnt_1_d   = 1'b0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and all registered outputs; reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      gnt_0_q        <= 1'b0;
      gnt_1_q        <= 1'b0;
      pool_valid_q   <= 1'b0;
      pool_data_q    <= '0;
      out_valid_0_q  <= 1'b0;
      out_valid_1_q  <= 1'b0;
      out_data_q     <= '0;
      frame_done_0_q <= 1'b0;
      frame_done_1_q <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      gnt_0_q        <= gnt_0_d;
      gnt_1_q        <= gnt_1_d;
      pool_valid_q   <= pix_accept;
      if (pix_accept) begin
        pool_data_q <= data_g;
      end
      out_valid_0_q  <= res_accept & gnt_0_q;
      out_valid_1_q  <= res_accept & gnt_1_q;
      if (res_accept) begin
        out_data_q <= {pool_max_3, pool_max_2, pool_max_1};
      end
      frame_done_0_q <= frame_end & gnt_0_q;
      frame_done_1_q <= frame_end & gnt_1_q;
      drop_q         <= drop;
    end
  end

  assign gnt_0           = gnt_0_q;
  assign gnt_1           = gnt_1_q;
  assign pool_valid_in   = pool_valid_q;
  assign pool_conv_out_1 = pool_data_q[CONV_BIT-1:0];
  assign pool_conv_out_2 = pool_data_q[2*CONV_BIT-1:CONV_BIT];
  assign pool_conv_out_3 = pool_data_q[3*CONV_BIT-1:2*CONV_BIT];
  assign out_valid_0     = out_valid_0_q;
  assign out_valid_1     = out_valid_1_q;
  assign out_data        = out_data_q;
  assign frame_done_0    = frame_done_0_q;
  assign frame_done_1    = frame_done_1_q;
  assign drop_err        = drop_q;

endmodule

// File: tb/tb_pool_frame_scheduler.sv
// Self-checking bench for pool_frame_scheduler with a behavioural ReLU/2x2
// max-pool model standing in for the shared pool unit.
module tb_pool_frame_scheduler;

  localparam int CB   = 12;
  localparam int IW   = 24;
  localparam int OW   = 12;
  localparam int NPIX = IW * IW;
  localparam int NOUT = OW * OW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_0 = 1'b0, req_1 = 1'b0;
  logic            gnt_0, gnt_1;
  logic            valid_0 = 1'b0, valid_1 = 1'b0;
  logic [3*CB-1:0] data_0 = '0, data_1 = '0;
  logic            pool_valid_in;
  logic [CB-1:0]   pool_conv_out_1, pool_conv_out_2, pool_conv_out_3;
  logic            pool_valid_out;
  logic [CB-1:0]   pool_max_1, pool_max_2, pool_max_3;
  logic            out_valid_0, out_valid_1;
  logic [3*CB-1:0] out_data;
  logic            frame_done_0, frame_done_1, drop_err;

  pool_frame_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .req_0           (req_0),
    .req_1           (req_1),
    .gnt_0           (gnt_0),
    .gnt_1           (gnt_1),
    .valid_0         (valid_0),
    .valid_1         (valid_1),
    .data_0          (data_0),
    .data_1          (data_1),
    .pool_valid_in   (pool_valid_in),
    .pool_conv_out_1 (pool_conv_out_1),
    .pool_conv_out_2 (pool_conv_out_2),
    .pool_conv_out_3 (pool_conv_out_3),
    .pool_valid_out  (pool_valid_out),
    .pool_max_1      (pool_max_1),
    .pool_max_2      (pool_max_2),
    .pool_max_3      (pool_max_3),
    .out_valid_0     (out_valid_0),
    .out_valid_1     (out_valid_1),
    .out_data        (out_data),
    .frame_done_0    (frame_done_0),
    .frame_done_1    (frame_done_1),
    .drop_err        (drop_err)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural pool: raster-order pixels, ReLU, 2x2 max, one-cycle latency
  // ---------------------------------------------------------------------
  logic signed [CB-1:0] mem1 [NPIX];
  logic signed [CB-1:0] mem2 [NPIX];
  logic signed [CB-1:0] mem3 [NPIX];
  int                   modelIdx;
  logic                 modelValid;
  logic [CB-1:0]        modelMax1, modelMax2, modelMax3;
  logic                 spuriousValid = 1'b0;

  function automatic logic [CB-1:0] maxRelu(input logic signed [CB-1:0] a, b, c, d);
    logic signed [CB-1:0] r;
    r = '0;
    if (a > r) r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    if (d > r) r = d;
    return r;
  endfunction

  // Pool model emits a result after the bottom-right pixel of each window
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelIdx = 0;
      modelValid <= 1'b0;
      modelMax1  <= '0;
      modelMax2  <= '0;
      modelMax3  <= '0;
    end else begin
      modelValid <= 1'b0;
      if (pool_valid_in) begin
        mem1[modelIdx] = pool_conv_out_1;
        mem2[modelIdx] = pool_conv_out_2;
        mem3[modelIdx] = pool_conv_out_3;
        if (((modelIdx / IW) % 2 == 1) && ((modelIdx % IW) % 2 == 1)) begin
          modelValid <= 1'b1;
          modelMax1 <= maxRelu(mem1[modelIdx], mem1[modelIdx-1], mem1[modelIdx-IW], mem1[modelIdx-IW-1]);
          modelMax2 <= maxRelu(mem2[modelIdx], mem2[modelIdx-1], mem2[modelIdx-IW], mem2[modelIdx-IW-1]);
          modelMax3 <= maxRelu(mem3[modelIdx], mem3[modelIdx-1], mem3[modelIdx-IW], mem3[modelIdx-IW-1]);
        end
        modelIdx = (modelIdx == NPIX - 1) ? 0 : modelIdx + 1;
      end
    end
  end

  assign pool_valid_out = modelValid | spuriousValid;
  assign pool_max_1     = modelMax1;
  assign pool_max_2     = modelMax2;
  assign pool_max_3     = modelMax3;

  // ---------------------------------------------------------------------
  // Stimulus generator and independent expected-result calculation
  // ---------------------------------------------------------------------
  function automatic logic [3*CB-1:0] ramp(input int p);
    return {12'(3 * p), 12'(287 - p), 12'(p - 288)};
  endfunction

  function automatic logic [3*CB-1:0] expResult(input int k);
    int wr, wc, p, m1, m2, m3;
    wr = k / OW;
    wc = k % OW;
    m1 = 0; m2 = 0; m3 = 0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        p = (2 * wr + dr) * IW + 2 * wc + dc;
        if (p - 288 > m1) m1 = p - 288;
        if (287 - p > m2) m2 = 287 - p;
        if (3 * p > m3) m3 = 3 * p;
      end
    end
    return {12'(m3), 12'(m2), 12'(m1)};
  endfunction

  // ---------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------
  int   checks = 0;
  int   errors = 0;
  int   pviCnt, ov0Cnt, ov1Cnt, fd0Cnt, fd1Cnt, dropCnt, outIdx;
  int   grantedReq = -1;
  logic pendAccept = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearCounts();
    pviCnt = 0; ov0Cnt = 0; ov1Cnt = 0;
    fd0Cnt = 0; fd1Cnt = 0; dropCnt = 0; outIdx = 0;
    grantedReq = -1;
  endtask

  task automatic driveGranted(input logic v, input logic [3*CB-1:0] d);
    if (grantedReq == 1) begin valid_1 = v; data_1 = d; end
    else begin valid_0 = v; data_0 = d; end
  endtask

  task automatic driveOther(input logic v, input logic [3*CB-1:0] d);
    if (grantedReq == 1) begin valid_0 = v; data_0 = d; end
    else begin valid_1 = v; data_1 = d; end
  endtask

  // One clock: sample just after the edge, count strobes, check streaming data
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("pool_valid_in", 64'(pool_valid_in), 64'(pendAccept));
    pendAccept = 1'b0;
    if (pool_valid_in) begin
      pviCnt++;
      checkOutput("no_abc_forwarded",
                  64'((pool_conv_out_1 == 12'hABC) || (pool_conv_out_2 == 12'hABC) ||
                      (pool_conv_out_3 == 12'hABC)), 64'd0);
    end
    if (out_valid_0) ov0Cnt++;
    if (out_valid_1) ov1Cnt++;
    if ((grantedReq == 0 && out_valid_0) || (grantedReq == 1 && out_valid_1)) begin
      if (outIdx < NOUT) checkOutput("out_data", 64'(out_data), 64'(expResult(outIdx)));
      outIdx++;
    end
    if (frame_done_0) fd0Cnt++;
    if (frame_done_1) fd1Cnt++;
    if (drop_err) dropCnt++;
  endtask

  typedef struct {
    bit r0;
    bit r1;
    bit hold;
    bit bubble;
    bit inject;
    int expReq;
    int expDrops;
  } frameVec_t;

  // Run one whole frame: grant, 576 pixels, drain, and frame-level checks
  task automatic applyStimulus(input frameVec_t v);
    int  waited, p, cyc;
    bit  injected;
    logic doneNow;
    clearCounts();
    req_0 = v.r0;
    req_1 = v.r1;
    waited = 0;
    while (!gnt_0 && !gnt_1 && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("grant_latency", 64'(waited), 64'd1);
    checkOutput("grant_owner", 64'({gnt_1, gnt_0}), (v.expReq == 1) ? 64'd2 : 64'd1);
    grantedReq = gnt_1 ? 1 : 0;
    if (!v.hold) begin
      req_0 = 1'b0;
      req_1 = 1'b0;
    end
    p = 0; cyc = 0; injected = 1'b0;
    while (p < NPIX) begin
      if (v.bubble && (cyc % 3 == 2)) begin
        driveGranted(1'b0, '0);
      end else begin
        driveGranted(1'b1, ramp(p));
        p++;
        pendAccept = 1'b1;
      end
      if (v.inject && !injected && p == 100) begin
        driveOther(1'b1, 36'hABCABCABC);
        injected = 1'b1;
      end
      tick();
      driveOther(1'b0, '0);
      cyc++;
    end
    driveGranted(1'b0, '0);
    waited = 0;
    doneNow = 1'b0;
    while (!doneNow && waited < 40) begin
      tick();
      waited++;
      doneNow = (grantedReq == 1) ? frame_done_1 : frame_done_0;
    end
    checkOutput("frame_done_seen", 64'(doneNow), 64'd1);
    checkOutput("gnt_low_at_done", 64'({gnt_1, gnt_0}), 64'd0);
    checkOutput("final_out_valid", 64'((grantedReq == 1) ? out_valid_1 : out_valid_0), 64'd1);
    checkOutput("pixels_to_pool", 64'(pviCnt), 64'(NPIX));
    checkOutput("results_granted", 64'((grantedReq == 1) ? ov1Cnt : ov0Cnt), 64'(NOUT));
    checkOutput("results_other", 64'((grantedReq == 1) ? ov0Cnt : ov1Cnt), 64'd0);
    checkOutput("frame_done_count", 64'(fd0Cnt + fd1Cnt), 64'd1);
    checkOutput("drop_count", 64'(dropCnt), 64'(v.expDrops));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({gnt_0, gnt_1, pool_valid_in, out_valid_0, out_valid_1,
                                     frame_done_0, frame_done_1, drop_err}), 64'd0);
    checkOutput({tag, "_pool_data"}, 64'({pool_conv_out_3, pool_conv_out_2, pool_conv_out_1}), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  // Hard stop if something hangs despite the bounded waits
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    frameVec_t vecs [6];
    int        waited;

    vecs[0] = '{r0: 1, r1: 1, hold: 1, bubble: 0, inject: 0, expReq: 0, expDrops: 0};
    vecs[1] = '{r0: 1, r1: 1, hold: 1, bubble: 0, inject: 0, expReq: 1, expDrops: 0};
    vecs[2] = '{r0: 1, r1: 1, hold: 0, bubble: 0, inject: 0, expReq: 0, expDrops: 0};
    vecs[3] = '{r0: 0, r1: 1, hold: 0, bubble: 1, inject: 0, expReq: 1, expDrops: 0};
    vecs[4] = '{r0: 1, r1: 0, hold: 0, bubble: 0, inject: 0, expReq: 0, expDrops: 0};
    vecs[5] = '{r0: 0, r1: 1, hold: 0, bubble: 0, inject: 1, expReq: 1, expDrops: 1};

    clearCounts();
    #1 rst = 1'b1;
    #2;
    $display("[TB] checking reset state");
    checkAllZero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] running frame table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] spurious pool result in IDLE");
    clearCounts();
    tick();
    spuriousValid = 1'b1;
    tick();
    spuriousValid = 1'b0;
    checkOutput("spurious_drop", 64'(drop_err), 64'd1);
    checkOutput("spurious_out_valid", 64'({out_valid_1, out_valid_0}), 64'd0);
    tick();
    checkOutput("spurious_drop_single", 64'(drop_err), 64'd0);
    checkOutput("spurious_out_valid_after", 64'({out_valid_1, out_valid_0}), 64'd0);

    $display("[TB] reset in the middle of a frame");
    clearCounts();
    req_0 = 1'b1;
    waited = 0;
    while (!gnt_0 && waited < 10) begin
      tick();
      waited++;
    end
    grantedReq = 0;
    req_0 = 1'b0;
    for (int p = 0; p < 301; p++) begin
      driveGranted(1'b1, ramp(p));
      pendAccept = 1'b1;
      tick();
    end
    driveGranted(1'b0, '0);
    checkOutput("pre_reset_gnt", 64'(gnt_0), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("midframe_reset");
    pendAccept = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus('{r0: 0, r1: 1, hold: 0, bubble: 0, inject: 0, expReq: 1, expDrops: 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
